// File: rtl/mnist_layer_mac.sv
// Streaming multiply-accumulate for one dense layer, N_NEUR lanes in parallel.
// Optional ReLU on the result lanes: define MNIST_LAYER_RELU_EN.
`timescale 1ns/1ps

module mnist_layer_mac #(
  parameter int N_IN   = 784,
  parameter int N_NEUR = 10,
  parameter int DW     = 8,
  parameter int WW     = 16,
  parameter int AW     = 32,
  localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  output logic [IW-1:0]        w_addr,
  output logic                 w_rden,
  input  logic [N_NEUR*WW-1:0] w_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_NEUR*AW-1:0] out_data,
  output logic                 busy
);

  localparam int PW = DW + 1 + WW;

  // One product must fit the accumulator; overflow headroom is left
  // to the caller's choice of AW.
  if (AW < PW) begin : g_aw_chk
    $error("mnist_layer_mac: AW narrower than one product");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [IW-1:0]        idx;
  logic [DW-1:0]        sample_q;
  logic                 mac_q;
  logic                 load_q;
  logic                 accept;
  logic                 last;
  logic signed [AW-1:0] acc  [N_NEUR];
  logic signed [AW-1:0] prod [N_NEUR];

  assign in_ready  = (state == IDLE) || (state == ACCUM);
  // Reset gates the read strobe so it drops without waiting for a clock.
  assign accept    = in_valid && in_ready && !clear && reset;
  assign last      = (idx == IW'(N_IN - 1));
  assign w_rden    = accept;
  assign w_addr    = idx;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: frame start, last sample, drain, output handshake.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = last ? DRAIN : ACCUM;
      end
      ACCUM: begin
        if (accept && last) state_nx = DRAIN;
      end
      DRAIN: begin
        state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (clear) state_nx = IDLE;
  end

  // Sample index and the one-cycle pipe that lines samples up with w_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      sample_q <= '0;
      mac_q    <= 1'b0;
      load_q   <= 1'b0;
    end else if (clear) begin
      idx    <= '0;
      mac_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      mac_q  <= accept;
      load_q <= accept && (idx == '0);
      if (accept) begin
        sample_q <= in_data;
        idx      <= last ? '0 : idx + IW'(1);
      end
    end
  end

  // Per-lane product of the zero-extended sample and the signed weight.
  always_comb begin
    for (int k = 0; k < N_NEUR; k++) begin
      prod[k] = AW'(PW'($signed({1'b0, sample_q}))
                    * PW'($signed(w_data[k*WW +: WW])));
    end
  end

  // Accumulators: first product of a frame loads, later ones add.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_NEUR; k++) acc[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < N_NEUR; k++) acc[k] <= '0;
    end else if (mac_q) begin
      for (int k = 0; k < N_NEUR; k++) begin
        acc[k] <= load_q ? prod[k] : acc[k] + prod[k];
      end
    end
  end

  // Result lanes, optionally clamped at zero.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < N_NEUR; k++) begin
`ifdef MNIST_LAYER_RELU_EN
      out_data[k*AW +: AW] = acc[k][AW-1] ? '0 : acc[k];
`else
      out_data[k*AW +: AW] = acc[k];
`endif
    end
  end

endmodule
